// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the pipeline controller and the execution-stage ALU.
// The master drives an operation; the slave returns result, compare outcome and handshake.
interface alu_multicycle_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            start;
  logic [3:0]      ALUctrl_lines;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [XLEN-1:0] result;
  logic            branch_taken;
  logic            busy;
  logic            done;

  modport master (
    output start, ALUctrl_lines, A, B,
    input  result, branch_taken, busy, done
  );

  modport slave (
    input  start, ALUctrl_lines, A, B,
    output result, branch_taken, busy, done
  );
endinterface

// File: rtl/alu_multicycle.sv
// Execution-stage ALU: single-cycle arithmetic/logic/shift/compare plus a fixed-latency
// iterative signed shift-add multiplier (MUL/MULH) behind a start/busy/done handshake.
module alu_multicycle #(
  parameter int unsigned XLEN = 32
) (
  input logic          clk,
  input logic          rst,
  alu_multicycle_if.slave bus
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned CW  = $clog2(XLEN);
  localparam int unsigned PW  = 2 * XLEN;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_BLT  = 4'b1000;
  localparam logic [3:0] OP_BGE  = 4'b1001;
  localparam logic [3:0] OP_BLTU = 4'b1010;
  localparam logic [3:0] OP_BGEU = 4'b1011;
  localparam logic [3:0] OP_BEQ  = 4'b1100;
  localparam logic [3:0] OP_BNE  = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b1110;
  localparam logic [3:0] OP_MULH = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic            sign_q;
  logic            high_q;

  logic            is_mul_c;
  logic            is_cmp_c;
  logic            load_c;
  logic            step_c;
  logic [SHW-1:0]  shamt_c;
  logic [XLEN-1:0] alu_res_c;
  logic            alu_br_c;
  logic [XLEN-1:0] abs_a_c;
  logic [XLEN-1:0] abs_b_c;
  logic [PW-1:0]   prod_c;
  logic [XLEN-1:0] fix_word_c;

  logic [XLEN-1:0] result_d;
  logic            branch_d;
  logic            done_d;

  assign is_mul_c = (bus.ALUctrl_lines == OP_MUL) || (bus.ALUctrl_lines == OP_MULH);
  assign is_cmp_c = bus.ALUctrl_lines[3] && !(bus.ALUctrl_lines[2] && bus.ALUctrl_lines[1]);
  assign shamt_c  = bus.B[SHW-1:0];

  // Single-cycle datapath; compare codes report the outcome as a zero-extended result.
  always_comb begin
    alu_res_c = '0;
    alu_br_c  = 1'b0;
    case (bus.ALUctrl_lines)
      OP_ADD:  alu_res_c = bus.A + bus.B;
      OP_SUB:  alu_res_c = bus.A - bus.B;
      OP_SLL:  alu_res_c = bus.A << shamt_c;
      OP_XOR:  alu_res_c = bus.A ^ bus.B;
      OP_SRL:  alu_res_c = bus.A >> shamt_c;
      OP_SRA:  alu_res_c = XLEN'($signed(bus.A) >>> shamt_c);
      OP_OR:   alu_res_c = bus.A | bus.B;
      OP_AND:  alu_res_c = bus.A & bus.B;
      OP_BLT:  alu_br_c  = $signed(bus.A) <  $signed(bus.B);
      OP_BGE:  alu_br_c  = $signed(bus.A) >= $signed(bus.B);
      OP_BLTU: alu_br_c  = bus.A <  bus.B;
      OP_BGEU: alu_br_c  = bus.A >= bus.B;
      OP_BEQ:  alu_br_c  = bus.A == bus.B;
      OP_BNE:  alu_br_c  = bus.A != bus.B;
      default: alu_res_c = '0;
    endcase
    if (is_cmp_c) begin
      alu_res_c = XLEN'(alu_br_c);
    end
  end

  // Magnitudes for the unsigned core; the most negative value maps onto itself.
  assign abs_a_c = bus.A[XLEN-1] ? (~bus.A + XLEN'(1)) : bus.A;
  assign abs_b_c = bus.B[XLEN-1] ? (~bus.B + XLEN'(1)) : bus.B;

  assign prod_c     = sign_q ? (~acc_q + PW'(1)) : acc_q;
  assign fix_word_c = high_q ? prod_c[PW-1:XLEN] : prod_c[XLEN-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && is_mul_c) begin
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/control decode; result and compare flag hold unless a request completes.
  always_comb begin
    result_d = bus.result;
    branch_d = bus.branch_taken;
    done_d   = 1'b0;
    load_c   = 1'b0;
    step_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (is_mul_c) begin
            load_c = 1'b1;
          end else begin
            result_d = alu_res_c;
            branch_d = alu_br_c;
            done_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        step_c = 1'b1;
      end
      S_FIX: begin
        result_d = fix_word_c;
        branch_d = 1'b0;
        done_d   = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Radix-2 shift-add core: one partial product per cycle, fixed iteration count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      high_q   <= 1'b0;
    end else if (load_c) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= PW'(abs_a_c);
      mplier_q <= abs_b_c;
      sign_q   <= bus.A[XLEN-1] ^ bus.B[XLEN-1];
      high_q   <= (bus.ALUctrl_lines == OP_MULH);
    end else if (step_c) begin
      cnt_q    <= cnt_q + CW'(1);
      acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result       <= '0;
      bus.branch_taken <= 1'b0;
      bus.done         <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      bus.result       <= result_d;
      bus.branch_taken <= branch_d;
      bus.done         <= done_d;
      bus.busy         <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized scoreboard bench for alu_multicycle: the driver predicts acceptance, result and
// completion cycle from the timing rules; a negedge monitor checks every cycle against them.
module tb_alu_multicycle;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_multicycle_if #(.XLEN(32)) bus_if ();

  alu_multicycle #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic [31:0] res;
    logic        br;
    int          done_cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc       = 0;
  int          checks    = 0;
  int          errors    = 0;
  int          free_cyc  = 0;
  int          busy_lo   = 0;
  int          busy_hi   = -1;
  int          rst_apply = -1;
  logic [31:0] hold_res  = '0;
  logic        hold_br   = 1'b0;
  logic        exp_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic and SV comparison operators.
  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic br);
    longint      sa, sbv, p;
    logic [63:0] pu;
    int          sh;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    sh  = int'(b[4:0]);
    r   = '0;
    br  = 1'b0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a << sh;
      4'd3:  r = a ^ b;
      4'd4:  r = a >> sh;
      4'd5:  r = 32'($signed(a) >>> sh);
      4'd6:  r = a | b;
      4'd7:  r = a & b;
      4'd8:  br = (sa < sbv);
      4'd9:  br = (sa >= sbv);
      4'd10: br = (a < b);
      4'd11: br = (a >= b);
      4'd12: br = (a == b);
      4'd13: br = (a != b);
      default: begin
        p  = sa * sbv;
        pu = p;
        r  = (op == 4'd15) ? pu[63:32] : pu[31:0];
      end
    endcase
    if (op >= 4'd8 && op <= 4'd13) r = {31'b0, br};
  endfunction

  // Drive one request for one cycle; the model decides whether it is accepted.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] r;
    logic        br;
    bus_if.start         = 1'b1;
    bus_if.ALUctrl_lines = op;
    bus_if.A             = a;
    bus_if.B             = b;
    if (cyc >= free_cyc) begin
      ref_op(op, a, b, r, br);
      e.res = r;
      e.br  = br;
      if (op >= 4'd14) begin
        e.done_cyc = cyc + 34;
        busy_lo    = cyc + 1;
        busy_hi    = cyc + 33;
        free_cyc   = cyc + 34;
      end else begin
        e.done_cyc = cyc + 1;
      end
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus_if.start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus_if.start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Reset for one cycle, optionally with a competing start that must lose.
  task automatic do_reset(input bit with_start);
    rst                  = 1'b1;
    bus_if.start         = with_start;
    bus_if.ALUctrl_lines = 4'd0;
    bus_if.A             = 32'd2;
    bus_if.B             = 32'd3;
    while (sb.size() > 0 && sb[$].done_cyc > cyc) void'(sb.pop_back());
    if (busy_hi > cyc) busy_hi = cyc;
    free_cyc  = cyc + 1;
    rst_apply = cyc + 1;
    @(posedge clk); #1;
    rst          = 1'b0;
    bus_if.start = 1'b0;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every cycle checks busy, done timing and the held/updated result.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (cyc == rst_apply) begin
        hold_res = '0;
        hold_br  = 1'b0;
      end
      while (sb.size() > 0 && sb[0].done_cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_done cycle=%0d actual=no_done required=done_at_%0d", cyc, sb[0].done_cyc);
        void'(sb.pop_front());
      end
      chk("busy", 32'(bus_if.busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      exp_done = (sb.size() > 0) && (sb[0].done_cyc == cyc);
      chk("done", 32'(bus_if.done), 32'(exp_done));
      if (exp_done) begin
        mon_e    = sb.pop_front();
        hold_res = mon_e.res;
        hold_br  = mon_e.br;
      end
      chk("result", bus_if.result, hold_res);
      chk("branch_taken", 32'(bus_if.branch_taken), 32'(hold_br));
    end
  end

  initial begin
    rst                  = 1'b1;
    bus_if.start         = 1'b0;
    bus_if.ALUctrl_lines = 4'd0;
    bus_if.A             = '0;
    bus_if.B             = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed single-cycle cases, back to back.
    issue(4'd0,  32'h7FFF_FFFF, 32'h1);
    issue(4'd1,  32'd5,         32'd7);
    issue(4'd5,  32'h8000_0000, 32'h24);
    issue(4'd4,  32'h8000_0000, 32'h24);
    issue(4'd8,  32'hFFFF_FFFF, 32'h1);
    issue(4'd10, 32'hFFFF_FFFF, 32'h1);
    issue(4'd12, 32'd5,         32'd5);
    issue(4'd13, 32'd5,         32'd5);
    idle(1);

    // Multiplies, each followed by a start in the first acceptable cycle.
    issue(4'd14, 32'd7,         32'hFFFF_FFFD); idle(33);
    issue(4'd14, 32'd0,         32'h1234_5678); idle(33);
    issue(4'd15, 32'h8000_0000, 32'h8000_0000); idle(33);
    issue(4'd15, 32'hFFFF_FFFF, 32'h1);         idle(33);
    issue(4'd15, 32'h7FFF_FFFF, 32'h7FFF_FFFF); idle(33);

    // Start during a multiply is dropped.
    issue(4'd14, 32'd9, 32'd11);
    idle(4);
    issue(4'd0, 32'd1, 32'd1);
    idle(28);

    // Reset mid-MULH, then a fresh ADD.
    issue(4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
    idle(9);
    do_reset(1'b0);
    issue(4'd0, 32'd2, 32'd3);
    idle(2);

    // Randomized traffic including dropped starts and occasional resets.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3)       do_reset(r[0]);
      else if (r < 60) issue(4'($urandom_range(0, 15)), rand_val(), rand_val());
      else             idle(1);
    end

    idle(40);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Execution-stage ALU that consumes the 4-bit `ALUctrl_lines` code produced by the ALU control decoder and performs the selected operation on two 32-bit operands. Arithmetic, logic, shift and branch-compare codes complete in one cycle. MUL and MULH run on an iterative signed shift-add multiplier with fixed latency. A start/busy/done handshake lets the pipeline controller stall while a multiply is in flight.

## Interface
- `XLEN`, 32: operand/result width; the design is verified at 32 only.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request; sampled only while `busy`=0.
- `ALUctrl_lines`  in  4: operation code, captured with `start`.
- `A`  in  32: operand rs1, captured with `start`.
- `B`  in  32: operand rs2/immediate, captured with `start`.
- `result`  out  32: registered result; holds until the next `done`.
- `branch_taken`  out  1: registered compare outcome; valid with `done`.
- `busy`  out  1: a multiply is in progress; `start` is ignored.
- `done`  out  1: one-cycle pulse; `result`/`branch_taken` are updated.

## Operation
- Codes: 0000 ADD, 0001 SUB, 0010 SLL, 0011 XOR, 0100 SRL, 0101 SRA, 0110 OR, 0111 AND, 1000 BLT, 1001 BGE, 1010 BLTU, 1011 BGEU, 1100 BEQ, 1101 BNE, 1110 MUL, 1111 MULH.
- Arithmetic is mod 2^32; no overflow flag.
- Shift amount is `B[4:0]`; SRA replicates `A[31]`.
- BLT/BGE are signed; BLTU/BGEU are unsigned.
- For codes 1000–1101:
  - `branch_taken` = compare outcome.
  - `result` = {31'b0, outcome}.
- For all other codes, `branch_taken` = 0.
- MUL returns the low 32 bits of signed A × signed B. MULH returns the high 32 bits of the 64-bit signed product.
- Multiplier datapath:
  - Capture |A| and |B| as 32-bit unsigned values; |0x80000000| = 0x80000000.
  - Record sign = A[31] ^ B[31].
  - Run 32 radix-2 shift-add iterations into a 64-bit accumulator.
  - In FIX, negate the 64-bit product (two's complement) if sign = 1.
  - Select the low or high word.
- FSM states:
  - IDLE: on `start`, a non-multiply code writes `result`/`branch_taken` and pulses `done`, staying in IDLE. Codes 1110/1111 load the operands, clear the counter and go to MUL.
  - MUL: one iteration per cycle; the counter runs 0..31. After the iteration at count 31, go to FIX.
  - FIX: write the sign-corrected word to `result`, pulse `done`, return to IDLE.
- `busy` = 1 in MUL and FIX.
- `start` during `busy` is dropped silently; it is not queued.
- Latency is fixed for every operand value, including zero.

## Timing
- Cycle N = the cycle in which `start`=1 is sampled in IDLE.
- Single-cycle ops:
  - `done`=1 and the new `result` appear in cycle N+1.
  - Back-to-back `start` every cycle gives one result per cycle.
- MUL/MULH:
  - `busy`=1 in cycles N+1..N+33.
  - `done`=1 and the new `result` appear in cycle N+34, with `busy`=0 in that cycle.
  - A new `start` is accepted in cycle N+34.
- `done` is never high for more than one consecutive cycle per request.
- Reset:
  - `result`=0, `branch_taken`=0, `busy`=0, `done`=0, state IDLE, counter 0.
  - Reset mid-multiply aborts with no `done`; outputs return to their reset values on the next cycle.
  - `rst` takes priority over a simultaneous `start`.
- `result` and `branch_taken` hold their values between `done` pulses, including throughout `busy`.

## Test plan
- ADD 0x7FFFFFFF + 1 → `result`=0x80000000, `done` in N+1. SUB 5 − 7 → 0xFFFFFFFE. SRA 0x80000000 by B=0x24 (shamt 4) → 0xF8000000. SRL of the same → 0x08000000.
- BLT A=0xFFFFFFFF, B=1 → `branch_taken`=1, `result`=1. BLTU with the same operands → 0. BEQ 5,5 → 1. BNE 5,5 → 0.
- MUL 7 × 0xFFFFFFFD (−3) → `result`=0xFFFFFFEB:
  - `busy` high for exactly 33 cycles.
  - `done` in N+34.
  - MUL 0 × 0x12345678 → 0, same latency.
- MULH cases:
  - 0x80000000 × 0x80000000 → 0x40000000.
  - 0xFFFFFFFF × 1 → 0xFFFFFFFF.
  - 0x7FFFFFFF × 0x7FFFFFFF → 0x3FFFFFFF.
- During a MUL, pulse `start` with ADD 1+1 at N+5 → the ADD is ignored. Only the MUL `done` occurs, at N+34, and `result` is unchanged until then.
- Assert `rst` at N+10 of a MULH → no `done`, outputs 0 from the next cycle. A new ADD 2+3 issued after reset → 5 one cycle later.
